// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - I/D cache miss arbiter for a single-ported fixed-latency memory
// One owner at a time; block reads are sequenced word by word, D-side writes are single words.
module mem_port_arbiter #(
  parameter int WORD_SIZE   = 16,
  parameter int OFFSET_BITS = 2,
  parameter int MEM_LATENCY = 4
) (
  input  logic                   Clk,
  input  logic                   Reset_N,
  input  logic                   i_req,
  input  logic [WORD_SIZE-1:0]   i_addr,
  output logic                   i_grant,
  output logic [WORD_SIZE-1:0]   i_rdata,
  output logic                   i_rvalid,
  output logic [OFFSET_BITS-1:0] i_rword,
  output logic                   i_done,
  input  logic                   d_req,
  input  logic                   d_we,
  input  logic [WORD_SIZE-1:0]   d_addr,
  input  logic [WORD_SIZE-1:0]   d_wdata,
  output logic                   d_grant,
  output logic [WORD_SIZE-1:0]   d_rdata,
  output logic                   d_rvalid,
  output logic [OFFSET_BITS-1:0] d_rword,
  output logic                   d_done,
  output logic                   m_readM,
  output logic                   m_writeM,
  output logic [WORD_SIZE-1:0]   m_address,
  output logic [WORD_SIZE-1:0]   m_wdata,
  input  logic [WORD_SIZE-1:0]   m_rdata,
  output logic                   mem_busy
);

  localparam int BLOCK_WORDS = 1 << OFFSET_BITS;
  localparam int LCNT_W      = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [LCNT_W-1:0]      LAST_LCNT = LCNT_W'(MEM_LATENCY - 1);
  localparam logic [OFFSET_BITS-1:0] LAST_WORD = OFFSET_BITS'(BLOCK_WORDS - 1);

  typedef enum logic {S_IDLE = 1'b0, S_XFER = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic                   own_dside_q, own_dside_d;
  logic                   is_write_q, is_write_d;
  logic                   last_dside_q, last_dside_d;
  logic [WORD_SIZE-1:0]   base_q, base_d;
  logic [WORD_SIZE-1:0]   wdata_q, wdata_d;
  logic [OFFSET_BITS-1:0] wcnt_q, wcnt_d;
  logic [LCNT_W-1:0]      lcnt_q, lcnt_d;

  logic xfer, word_done, xfer_done, win_dside, rd_valid;

  assign xfer      = (state_q == S_XFER);
  assign word_done = xfer && (lcnt_q == LAST_LCNT);
  assign xfer_done = word_done && (is_write_q || (wcnt_q == LAST_WORD));
  // Ties go to the side that did not win last time
  assign win_dside = d_req && (!i_req || !last_dside_q);
  assign rd_valid  = word_done && !is_write_q;

  always_comb begin
    state_d      = state_q;
    own_dside_d  = own_dside_q;
    is_write_d   = is_write_q;
    last_dside_d = last_dside_q;
    base_d       = base_q;
    wdata_d      = wdata_q;
    wcnt_d       = wcnt_q;
    lcnt_d       = lcnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          own_dside_d  = win_dside;
          last_dside_d = win_dside;
          is_write_d   = win_dside && d_we;
          base_d       = win_dside ? d_addr : i_addr;
          wdata_d      = (win_dside && d_we) ? d_wdata : '0;
          wcnt_d       = '0;
          lcnt_d       = '0;
          state_d      = S_XFER;
        end
      end
      S_XFER: begin
        if (word_done) begin
          lcnt_d = '0;
          wcnt_d = wcnt_q + OFFSET_BITS'(1);
          if (xfer_done) begin
            state_d = S_IDLE;
          end
        end else begin
          lcnt_d = lcnt_q + LCNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      state_q      <= S_IDLE;
      own_dside_q  <= 1'b0;
      is_write_q   <= 1'b0;
      last_dside_q <= 1'b0;
      base_q       <= '0;
      wdata_q      <= '0;
      wcnt_q       <= '0;
      lcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      own_dside_q  <= own_dside_d;
      is_write_q   <= is_write_d;
      last_dside_q <= last_dside_d;
      base_q       <= base_d;
      wdata_q      <= wdata_d;
      wcnt_q       <= wcnt_d;
      lcnt_q       <= lcnt_d;
    end
  end

  // Read addresses take the block base from the latched address and the offset from wcnt
  assign mem_busy  = xfer;
  assign i_grant   = xfer && !own_dside_q;
  assign d_grant   = xfer && own_dside_q;
  assign m_readM   = xfer && !is_write_q;
  assign m_writeM  = xfer && is_write_q;
  assign m_address = !xfer ? '0 :
                     is_write_q ? base_q : {base_q[WORD_SIZE-1:OFFSET_BITS], wcnt_q};
  assign m_wdata   = m_writeM ? wdata_q : '0;

  assign i_rvalid  = rd_valid && !own_dside_q;
  assign d_rvalid  = rd_valid && own_dside_q;
  assign i_rdata   = i_rvalid ? m_rdata : '0;
  assign d_rdata   = d_rvalid ? m_rdata : '0;
  assign i_rword   = i_rvalid ? wcnt_q : '0;
  assign d_rword   = d_rvalid ? wcnt_q : '0;
  assign i_done    = xfer_done && !own_dside_q;
  assign d_done    = xfer_done && own_dside_q;

endmodule
